// File: rtl/st_frame_packer.sv
// Avalon-ST re-framing FIFO: stores beats with regenerated sop/eop so that the
// downstream DMA sees fixed-length frames, closed early by an input eop.
module st_frame_packer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [LEN_W-1:0]         frame_len,
  output logic                     sink_ready,
  input  logic [DATA_W-1:0]        sink_data,
  input  logic                     sink_valid,
  input  logic                     sink_sop,
  input  logic                     sink_eop,
  output logic [DATA_W-1:0]        source_data,
  output logic                     source_valid,
  output logic                     source_sop,
  output logic                     source_eop,
  input  logic                     source_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [LEN_W-1:0]         frame_count,
  output logic [LEN_W-1:0]         short_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LEN_W-1:0]  idx, len_q, len_eff, cur_len;
  logic              push, pop, last, st_sop, st_eop;
  logic [DATA_W+1:0] head;
  logic              sop_unused;

  // Framing comes only from idx/len_q/sink_eop; the input sop carries no meaning here.
  assign sop_unused = sink_sop;

  assign sink_ready   = rst_n && enable && (fill_level != FULL);
  assign push         = sink_valid && sink_ready;
  assign source_valid = (fill_level != '0);
  assign pop          = source_valid && source_ready;

  assign len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign cur_len = (idx == '0) ? len_eff : len_q;
  assign last    = (idx == cur_len - LEN_W'(1));
  assign st_sop  = (idx == '0);
  assign st_eop  = last || sink_eop;

  // Outputs are forced to zero while empty so nothing stale or unknown leaks out.
  assign head        = mem[rd_ptr];
  assign source_data = source_valid ? head[DATA_W-1:0] : '0;
  assign source_eop  = source_valid && head[DATA_W];
  assign source_sop  = source_valid && head[DATA_W+1];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {st_sop, st_eop, sink_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fill_level <= fill_level + (AW+1)'(1);
      else if (!push && pop) fill_level <= fill_level - (AW+1)'(1);
    end
  end

  // len_q is latched only at a frame start, so mid-frame frame_len edits wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      len_q       <= '0;
      short_count <= '0;
    end else if (push) begin
      if (idx == '0) len_q <= len_eff;
      idx <= st_eop ? '0 : idx + LEN_W'(1);
      if (sink_eop && !last) short_count <= short_count + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      frame_count <= '0;
    else if (pop && head[DATA_W])    frame_count <= frame_count + LEN_W'(1);
  end

endmodule

// File: tb/tb_st_frame_packer.sv
// Self-checking bench for st_frame_packer: directed scenarios plus random
// traffic compared against a queue-based frame model.
module tb_st_frame_packer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 16;

  logic              clk, rst_n, enable;
  logic [LEN_W-1:0]  frame_len;
  logic              sink_ready, sink_valid, sink_sop, sink_eop;
  logic [DATA_W-1:0] sink_data, source_data;
  logic              source_valid, source_sop, source_eop, source_ready;
  logic [$clog2(DEPTH):0] fill_level;
  logic [LEN_W-1:0]  frame_count, short_count;

  st_frame_packer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_len(frame_len),
    .sink_ready(sink_ready), .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready),
    .fill_level(fill_level), .frame_count(frame_count), .short_count(short_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {sop,eop,data} plus position within the current frame.
  logic [DATA_W+1:0] mq[$];
  logic [DATA_W+1:0] obs_q[$];
  logic [DATA_W+1:0] exp_q[$];
  logic [LEN_W-1:0]  m_pos, m_flen, m_frames, m_short;
  int rdy_bad, vld_bad, fill_bad;

  task automatic model_clear();
    mq.delete(); obs_q.delete(); exp_q.delete();
    m_pos = '0; m_flen = '0; m_frames = '0; m_short = '0;
    rdy_bad = 0; vld_bad = 0; fill_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; frame_len = '0; sink_valid = 1'b0;
    sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0; source_ready = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance one cycle; called at a falling edge with inputs already applied.
  task automatic step();
    logic [LEN_W-1:0] flen;
    logic m_rdy, m_acc, m_pop, at_end, e;
    logic [DATA_W+1:0] ent;
    #1;
    m_rdy = enable && (mq.size() != DEPTH);
    m_acc = sink_valid && m_rdy;
    m_pop = (mq.size() != 0) && source_ready;
    if (sink_ready !== m_rdy) rdy_bad++;
    if (source_valid !== (mq.size() != 0)) vld_bad++;
    if (fill_level != mq.size()) fill_bad++;
    if (m_pop) begin
      obs_q.push_back({source_sop, source_eop, source_data});
      ent = mq.pop_front();
      exp_q.push_back(ent);
      if (ent[DATA_W]) m_frames++;
    end
    if (m_acc) begin
      if (m_pos == 0) m_flen = (frame_len == 0) ? LEN_W'(1) : frame_len;
      flen   = m_flen;
      at_end = (int'(m_pos) + 1 == int'(flen));
      e      = at_end || sink_eop;
      if (sink_eop && !at_end) m_short++;
      mq.push_back({(m_pos == 0), e, sink_data});
      m_pos = e ? '0 : m_pos + 1'b1;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic e);
    sink_valid = 1'b1; sink_data = d; sink_eop = e; sink_sop = $urandom_range(0, 1);
    step();
    sink_valid = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    sink_valid = 1'b0; source_ready = 1'b1;
    while ((mq.size() != 0 || n < 2) && n < 200) begin step(); n++; end
    checks++;
    if (mq.size() != 0) begin
      errors++; $display("FAIL drain_timeout got %0d left want 0", mq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; sink_valid = 1'b1; source_ready = 1'b1;
    #1;
    checks++;
    if ({source_valid, source_sop, source_eop, sink_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {source_valid, source_sop, source_eop, sink_ready});
    end
    checks++;
    if ({source_data, fill_level, frame_count, short_count} !== '0) begin
      errors++; $display("FAIL reset_vals got %h/%0d/%0d/%0d want 0", source_data, fill_level, frame_count, short_count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    frame_len = 4; source_ready = 1'b1;
    #1;
    checks++;
    if (source_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b want 0", source_valid); end
    beat(1, 0);
    checks++;
    if ({source_valid, source_sop, source_data} !== {2'b11, 32'h1}) begin
      errors++; $display("FAIL basic_latency got %b/%b/%h want 1/1/1", source_valid, source_sop, source_data);
    end
    for (int i = 2; i <= 8; i++) beat(i, 0);
    drain();
    checks++;
    if (obs_q.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== {2'b10, 32'h1} || obs_q[3] !== {2'b01, 32'h4} ||
          obs_q[4] !== {2'b10, 32'h5} || obs_q[7] !== {2'b01, 32'h8}) begin
        errors++; $display("FAIL basic_frames got %h %h %h %h want 200000001 100000004 200000005 100000008",
                           obs_q[0], obs_q[3], obs_q[4], obs_q[7]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL basic_frame_count got %0d want 2", frame_count); end
    checks++;
    if (rdy_bad + vld_bad + fill_bad != 0) begin
      errors++; $display("FAIL basic_handshake got %0d/%0d/%0d bad cycles want 0", rdy_bad, vld_bad, fill_bad);
    end
  endtask

  task automatic test_full();
    do_reset();
    frame_len = 4; source_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) beat(32'h100 + i, 0);
    #1;
    checks++;
    if (fill_level !== 5'd16 || sink_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got fill=%0d ready=%b want 16/0", fill_level, sink_ready);
    end
    source_ready = 1'b1;
    beat(32'h99, 0);
    source_ready = 1'b0;
    checks++;
    if (fill_level !== 5'd15) begin errors++; $display("FAIL full_pop_fill got %0d want 15", fill_level); end
    drain();
    checks++;
    if (obs_q.size() != DEPTH) begin errors++; $display("FAIL full_count got %0d want %0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (rdy_bad + vld_bad + fill_bad != 0) begin
      errors++; $display("FAIL full_handshake got %0d/%0d/%0d bad cycles want 0", rdy_bad, vld_bad, fill_bad);
    end
  endtask

  task automatic test_short();
    do_reset();
    frame_len = 8; source_ready = 1'b1;
    beat(32'hA1, 0); beat(32'hA2, 0); beat(32'hA3, 1); beat(32'hA4, 0);
    drain();
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL short_count_beats got %0d want 4", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0][DATA_W+1:DATA_W] !== 2'b10 || obs_q[1][DATA_W+1:DATA_W] !== 2'b00 ||
          obs_q[2][DATA_W+1:DATA_W] !== 2'b01 || obs_q[3][DATA_W+1:DATA_W] !== 2'b10) begin
        errors++; $display("FAIL short_flags got %h %h %h %h want sop,none,eop,sop", obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
      end
    end
    checks++;
    if (short_count !== 16'd1) begin errors++; $display("FAIL short_counter got %0d want 1", short_count); end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL short_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_len0();
    do_reset();
    frame_len = 0; source_ready = 1'b1;
    beat(32'hB1, 0); beat(32'hB2, 0); beat(32'hB3, 0);
    drain();
    checks++;
    if (obs_q.size() != 3) begin errors++; $display("FAIL len0_count got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i][DATA_W+1:DATA_W] !== 2'b11) begin
        errors++; $display("FAIL len0_flags%0d got %b want 11", i, obs_q[i][DATA_W+1:DATA_W]);
      end
    end
    checks++;
    if (frame_count !== 16'd3 || short_count !== 16'd0) begin
      errors++; $display("FAIL len0_counters got %0d/%0d want 3/0", frame_count, short_count);
    end
  endtask

  task automatic test_len_change();
    do_reset();
    frame_len = 4; source_ready = 1'b1;
    beat(32'hC1, 0); beat(32'hC2, 0);
    frame_len = 2;
    for (int i = 3; i <= 6; i++) beat(32'hC0 + i, 0);
    drain();
    checks++;
    if (obs_q.size() != 6) begin errors++; $display("FAIL lenchg_count got %0d want 6", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[2][DATA_W] !== 1'b0 || obs_q[3][DATA_W] !== 1'b1 ||
          obs_q[4][DATA_W+1] !== 1'b1 || obs_q[5][DATA_W] !== 1'b1) begin
        errors++; $display("FAIL lenchg_flags got %h %h %h %h want eop on 4th and 6th, sop on 5th",
                           obs_q[2], obs_q[3], obs_q[4], obs_q[5]);
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL lenchg_frame_count got %0d want 2", frame_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) frame_len = LEN_W'($urandom_range(0, 6));
      enable       = ($urandom_range(0, 9) != 0);
      source_ready = ($urandom_range(0, 9) < 6);
      sink_valid   = ($urandom_range(0, 9) < 7);
      sink_eop     = ($urandom_range(0, 9) == 0);
      sink_sop     = $urandom_range(0, 1);
      sink_data    = $urandom;
      step();
    end
    enable = 1'b1; sink_eop = 1'b0;
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== m_frames || short_count !== m_short) begin
      errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", frame_count, short_count, m_frames, m_short);
    end
    checks++;
    if (rdy_bad + vld_bad + fill_bad != 0) begin
      errors++; $display("FAIL rand_handshake got %0d/%0d/%0d bad cycles want 0", rdy_bad, vld_bad, fill_bad);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    frame_len = 5; source_ready = 1'b0;
    beat(32'hD1, 0); beat(32'hD2, 0); beat(32'hD3, 1); beat(32'hD4, 0); beat(32'hD5, 0);
    checks++;
    if (fill_level !== 5'd5 || short_count !== 16'd1) begin
      errors++; $display("FAIL mrst_pre got fill=%0d short=%0d want 5/1", fill_level, short_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({source_valid, sink_ready} !== 2'b00 || fill_level !== '0 || frame_count !== '0 || short_count !== '0) begin
      errors++; $display("FAIL mrst_immediate got valid=%b ready=%b fill=%0d fc=%0d sc=%0d want 0",
                         source_valid, sink_ready, fill_level, frame_count, short_count);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; source_ready = 1'b1;
    beat(32'hAB, 0);
    drain();
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL mrst_count got %0d want 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== {2'b10, 32'hAB}) begin errors++; $display("FAIL mrst_first got %h want 2000000ab", obs_q[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_len = '0; sink_valid = 1'b0; sink_sop = 1'b0;
    sink_eop = 1'b0; sink_data = '0; source_ready = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_short();
    test_len0();
    test_len_change();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
